// File: rtl/instr_loader_pkg.sv
// Shared constants for the boot-time instruction loader.
package instr_loader_pkg;

    localparam logic [2:0] LD_LEN_HI = 3'd0;
    localparam logic [2:0] LD_LEN_LO = 3'd1;
    localparam logic [2:0] LD_LOAD   = 3'd2;
    localparam logic [2:0] LD_CHECK  = 3'd3;
    localparam logic [2:0] LD_DONE   = 3'd4;
    localparam logic [2:0] LD_ERROR  = 3'd5;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid pulses for one
// cycle after the last byte of each word, while word_data holds the word.
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        word_valid_q, word_valid_d;

    assign last_byte  = (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_valid = word_valid_q;
    assign word_data  = shift_q;

    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        word_valid_d = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_en) begin
            cnt_d        = cnt_q + 2'd1;
            shift_d      = {shift_q[23:0], byte_in};
            word_valid_d = last_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image, writes it
// to instruction memory and releases the core from reset once it verifies.
//
// state     | meaning
// LEN_HI    | waiting for word-count high byte
// LEN_LO    | waiting for word-count low byte
// LOAD      | packing payload bytes into words and writing them
// CHECK     | comparing the checksum byte against the running XOR
// DONE      | image verified, core released (terminal)
// ERROR     | image rejected, bytes swallowed (terminal)
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);

    logic [2:0]            state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [7:0]            chk_q, chk_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           words_q, words_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;

    logic        accept;
    logic        in_load;
    logic [15:0] n_words;
    logic        last_byte;
    logic        word_valid;
    logic [31:0] word_data;

    assign accept  = rx_valid & rx_ready;
    assign in_load = (state_q == LD_LOAD);
    assign n_words = {len_hi_q, rx_data};

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (!in_load),
        .byte_en    (in_load && accept),
        .byte_in    (rx_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LD_LEN_HI;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_LEN_HI: if (accept) state_d = LD_LEN_LO;
            LD_LEN_LO: begin
                if (accept) begin
                    if (n_words == 16'd0)                 state_d = LD_CHECK;
                    else if (n_words > 16'(MAX_WORDS))    state_d = LD_ERROR;
                    else                                  state_d = LD_LOAD;
                end
            end
            LD_LOAD:   if (accept && last_byte && remaining_q == 16'd1) state_d = LD_CHECK;
            LD_CHECK:  if (accept) state_d = (rx_data == chk_q) ? LD_DONE : LD_ERROR;
            LD_DONE:   state_d = LD_DONE;
            LD_ERROR:  state_d = LD_ERROR;
            default:   state_d = LD_LEN_HI;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            LD_LEN_HI, LD_LEN_LO, LD_LOAD, LD_CHECK, LD_ERROR: rx_ready = 1'b1;
            default: rx_ready = 1'b0;
        endcase
    end

    // Status flags follow the state register, so cpu_reset drops one edge after DONE.
    always_comb begin
        len_hi_d     = len_hi_q;
        remaining_d  = remaining_q;
        chk_d        = chk_q;
        addr_d       = addr_q;
        words_d      = words_q;
        cpu_reset_d  = (state_q != LD_DONE);
        load_done_d  = (state_q == LD_DONE);
        load_error_d = (state_q == LD_ERROR);
        if (accept && state_q == LD_LEN_HI) len_hi_d = rx_data;
        if (accept && state_q == LD_LEN_LO) remaining_d = n_words;
        if (accept && in_load) begin
            chk_d = chk_q ^ rx_data;
            if (last_byte) remaining_d = remaining_q - 16'd1;
        end
        if (word_valid) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            words_d = words_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi_q     <= '0;
            remaining_q  <= '0;
            chk_q        <= '0;
            addr_q       <= '0;
            words_q      <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            len_hi_q     <= len_hi_d;
            remaining_q  <= remaining_d;
            chk_q        <= chk_d;
            addr_q       <= addr_d;
            words_q      <= words_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign imem_we      = word_valid;
    assign imem_addr    = addr_q;
    assign imem_wdata   = word_data;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected memory writes are queued by the
// stimulus and popped by a monitor that watches imem_we.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [39:0] exp_q[$];

    instr_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT makes must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr 0x%02h data 0x%08h, none expected", imem_addr, imem_wdata);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL imem_write: got addr 0x%02h data 0x%08h expected addr 0x%02h data 0x%08h",
                             imem_addr, imem_wdata, e[39:32], e[31:0]);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_queue_empty(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    logic [7:0] nominal[11] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    int gap_pos[3];

    initial begin
        do_reset();
        chk("rst_rx_ready",     rx_ready, 1);
        chk("rst_imem_we",      imem_we, 0);
        chk("rst_imem_addr",    imem_addr, 0);
        chk("rst_imem_wdata",   imem_wdata, 0);
        chk("rst_cpu_reset",    cpu_reset, 1);
        chk("rst_load_done",    load_done, 0);
        chk("rst_load_error",   load_error, 0);
        chk("rst_words_loaded", words_loaded, 0);

        // Nominal back-to-back load with cpu_reset latency check.
        exp_q.push_back({8'h00, 32'h2008_0005});
        exp_q.push_back({8'h01, 32'h0000_0000});
        for (int i = 0; i < 11; i++) send(nominal[i], 0);
        chk("nom_cpu_reset_still_high", cpu_reset, 1);
        idle(1);
        chk("nom_cpu_reset_low", cpu_reset, 0);
        chk("nom_load_done", load_done, 1);
        chk("nom_load_error", load_error, 0);
        chk("nom_words_loaded", words_loaded, 2);
        chk("nom_rx_ready_done", rx_ready, 0);
        check_queue_empty("nom_all_writes_seen");

        // Bad checksum: ends in ERROR and swallows extra bytes without writing.
        do_reset();
        exp_q.push_back({8'h00, 32'h2008_0005});
        exp_q.push_back({8'h01, 32'h0000_0000});
        for (int i = 0; i < 10; i++) send(nominal[i], 0);
        send(8'h2C, 0);
        idle(1);
        chk("bad_load_error", load_error, 1);
        chk("bad_load_done", load_done, 0);
        chk("bad_cpu_reset", cpu_reset, 1);
        for (int i = 0; i < 8; i++) send(8'hA5 + 8'(i), 0);
        chk("bad_rx_ready", rx_ready, 1);
        chk("bad_words_loaded", words_loaded, 2);
        check_queue_empty("bad_all_writes_seen");

        // Zero-length image.
        do_reset();
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        idle(2);
        chk("zero_load_done", load_done, 1);
        chk("zero_cpu_reset", cpu_reset, 0);
        chk("zero_words_loaded", words_loaded, 0);
        check_queue_empty("zero_no_writes");

        // Oversize image rejected straight after the length.
        do_reset();
        send(8'h01, 0); send(8'h01, 0);
        idle(1);
        chk("big_load_error", load_error, 1);
        chk("big_cpu_reset", cpu_reset, 1);
        for (int i = 0; i < 6; i++) send(8'h11, 0);
        chk("big_rx_ready", rx_ready, 1);
        chk("big_words_loaded", words_loaded, 0);
        check_queue_empty("big_no_writes");

        // Gapped stream: three single-cycle bubbles at random byte positions.
        do_reset();
        for (int g = 0; g < 3; g++) gap_pos[g] = int'($urandom_range(1, 10));
        exp_q.push_back({8'h00, 32'h2008_0005});
        exp_q.push_back({8'h01, 32'h0000_0000});
        for (int i = 0; i < 11; i++) begin
            int gap;
            gap = 0;
            for (int g = 0; g < 3; g++) if (gap_pos[g] == i) gap++;
            send(nominal[i], gap);
        end
        idle(2);
        chk("gap_load_done", load_done, 1);
        chk("gap_cpu_reset", cpu_reset, 0);
        chk("gap_words_loaded", words_loaded, 2);
        check_queue_empty("gap_all_writes_seen");

        // Asynchronous reset right after the first word completes.
        do_reset();
        for (int i = 0; i < 6; i++) send(nominal[i], 0);
        reset = 1'b1;
        #1;
        chk("mid_imem_we", imem_we, 0);
        chk("mid_cpu_reset", cpu_reset, 1);
        chk("mid_imem_addr", imem_addr, 0);
        chk("mid_words_loaded", words_loaded, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back({8'h00, 32'h2008_0005});
        exp_q.push_back({8'h01, 32'h0000_0000});
        for (int i = 0; i < 11; i++) send(nominal[i], 0);
        idle(2);
        chk("mid_replay_done", load_done, 1);
        chk("mid_replay_words", words_loaded, 2);
        check_queue_empty("mid_replay_writes_seen");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
